module_cla_accumulator_8bits: RTL and testbench
===============================================

// Module: module_cla_accumulator_8bits
// PURPOSE
// - Upstream operand stage for the 8-bit CLA adder (module_cla_8bits).
// - Accepts a stream of N_OPS operands over a valid/ready handshake.
// - Accumulates them through the CLA and presents the registered sum, a sticky overflow flag and a done flag.
// - Holds the result until acknowledged; a downstream consumer (display/UART stage) reads result_po while done_po=1.
// PARAMETERS
// - WIDTH2  8  operand/accumulator width, passed through to module_cla_8bits.
// - N_OPS   4  operands per accumulation; legal range 2..15.
// - CNT_W   $clog2(N_OPS+1)  localparam, width of count_po.
// PORTS
// - clk_pi     in   1       single clock; all state updates on the rising edge.
// - rst_pi     in   1       asynchronous, active-high reset.
// - clear_pi   in   1       synchronous abort/clear.
// - data_pi    in   WIDTH2  operand.
// - valid_pi   in   1       data_pi valid.
// - ready_po   out  1       stage can accept an operand.
// - ack_pi     in   1       consumer has taken the result.
// - result_po  out  WIDTH2  accumulated sum, modulo 2^WIDTH2.
// - ovf_po     out  1       sticky: at least one addition wrapped.
// - count_po   out  CNT_W   operands accepted in the current accumulation.
// - done_po    out  1       result_po final and stable.
// BEHAVIOUR
// - Reset (async, rst_pi=1): state=ST_IDLE, acc=0, result_po=0, ovf_po=0, count_po=0, done_po=0, ready_po=1.
//   Outputs take these values immediately, not at the next edge.
// - Beat = rising edge with valid_pi && ready_po; data_pi is sampled only on a beat.
// - ready_po = (state != ST_DONE); decoded from state, no combinational path from valid_pi.
// - done_po = (state == ST_DONE).
// - result_po is the acc register itself.
// - CLA connection: a_pi = acc, b_pi = data_pi; sum = CLA result_po.
//   wrap = (sum < acc), unsigned compare; CLA has no carry-out.
// - ST_IDLE: acc=0. On a beat: acc<=sum (=data_pi), count<=1, go ST_ACC.
// - ST_ACC, on a beat: acc<=sum, ovf<=ovf|wrap, count<=count+1.
//   If count==N_OPS-1 at the beat, go ST_DONE.
// - ST_ACC, no beat: hold all registers; valid_pi gaps of any length are allowed.
// - ST_DONE: all registers hold; valid_pi ignored.
//   ack_pi=1 -> ST_IDLE, acc<=0, ovf<=0, count<=0.
// - ack_pi outside ST_DONE: ignored.
// - Latency: result_po/done_po valid on the cycle after the N_OPS-th beat; throughput 1 operand/cycle.
// - Priority, highest first: rst_pi > clear_pi > ack_pi/beat.
//   clear_pi=1: next state ST_IDLE, acc/ovf/count <= 0; any beat in that cycle is dropped.
//   This applies in every state.
// - Wrap-around: sums are taken modulo 2^WIDTH2; ovf_po records the wrap but does not saturate.
// - Reset mid-accumulation discards the partial sum; the first operand after release starts a new accumulation.
// STRUCTURE
// - Package cla_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} cla_acc_state_t
//   - localparam CLA_WIDTH = 8
// - Sub-module: one instance of module_cla_8bits #(.WIDTH2(WIDTH2)) u_cla (a_pi=acc, b_pi=data_pi).
// - Logic: one always_ff (state, acc, ovf, count) plus one always_comb (next state, ready, done).
// TESTING
// - Basic: beats 10,20,30,40 back-to-back -> result_po=100, ovf_po=0, done_po=1 one cycle after the 4th beat.
// - Wrap: beats 200,100,0,0 -> result_po=44, ovf_po=1.
// - Gaps: beats 1,2,3,4 with 3 idle cycles between each -> result_po=10; count_po steps 1,2,3,4.
// - Hold: in ST_DONE drive valid_pi=1 with data 99 for 5 cycles -> result_po stays 100, ready_po=0.
//   Then ack_pi -> ready_po=1, count_po=0.
// - Clear: after beats 50,60, pulse clear_pi together with valid_pi (data 7) -> count_po=0, operand 7 dropped.
//   Then beats 1,2,3,4 -> result_po=10.
// - Async reset: assert rst_pi mid-ST_ACC between clock edges -> result_po=0, count_po=0 before the next edge.
//   After release, beats 5,5,5,5 -> result_po=20.

Source files
------------

// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared types and constants for the CLA adder and its accumulator front end.
//   cla_acc_state_t : accumulator control states (idle, accumulating, done)
//   CLA_WIDTH       : default datapath width of the CLA adder
// ---------------------------------------------------------------------------
package cla_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } cla_acc_state_t;

   localparam int CLA_WIDTH = 8;

endpackage : cla_pkg

// File: rtl/module_cla_8bits.sv
// ---------------------------------------------------------------------------
// module_cla_8bits
// Purely combinational carry-lookahead adder. The sum wraps modulo
// 2^WIDTH2 and there is no carry-out; callers detect a wrap themselves.
// Ports:
//   a_pi      in  WIDTH2  first addend
//   b_pi      in  WIDTH2  second addend
//   result_po out WIDTH2  (a_pi + b_pi) mod 2^WIDTH2
// ---------------------------------------------------------------------------
module module_cla_8bits
   import cla_pkg::*;
#(
   parameter int WIDTH2 = CLA_WIDTH
) (
   input  logic [WIDTH2-1:0] a_pi,
   input  logic [WIDTH2-1:0] b_pi,
   output logic [WIDTH2-1:0] result_po
);

   logic [WIDTH2-1:0] gen;
   logic [WIDTH2-1:0] prop;
   logic [WIDTH2-1:0] carry;

   assign gen  = a_pi & b_pi;
   assign prop = a_pi ^ b_pi;

   // Each carry into bit i is written out in flat lookahead form: the OR over
   // every lower bit j that generates a carry and every bit between j and i
   // that propagates it. No carry depends on a previously computed carry, so
   // the depth stays two logic levels instead of a ripple chain.
   always_comb begin : carry_lookahead
      logic term;
      term  = 1'b0;
      carry = '0;
      for (int i = 1; i < WIDTH2; i++) begin
         for (int j = 0; j < i; j++) begin
            term = gen[j];
            for (int k = j + 1; k < i; k++) begin
               term = term & prop[k];
            end
            carry[i] = carry[i] | term;
         end
      end
   end

   assign result_po = prop ^ carry;

endmodule : module_cla_8bits

// File: rtl/module_cla_accumulator_8bits.sv
// ---------------------------------------------------------------------------
// module_cla_accumulator_8bits
// Operand stage in front of the CLA adder. Takes N_OPS operands over a
// valid/ready handshake, sums them through module_cla_8bits and holds the
// result with done_po high until the consumer acknowledges it.
// Ports:
//   clk_pi    in  1       rising-edge clock
//   rst_pi    in  1       asynchronous active-high reset
//   clear_pi  in  1       synchronous abort, wins over ack and beats
//   data_pi   in  WIDTH2  operand, sampled only on a beat
//   valid_pi  in  1       data_pi valid
//   ready_po  out 1       stage can accept an operand (not in ST_DONE)
//   ack_pi    in  1       consumer has taken the result (only used in ST_DONE)
//   result_po out WIDTH2  accumulated sum modulo 2^WIDTH2
//   ovf_po    out 1       sticky: at least one addition wrapped
//   count_po  out CNT_W   operands accepted in the current accumulation
//   done_po   out 1       result_po final and stable
// ---------------------------------------------------------------------------
module module_cla_accumulator_8bits
   import cla_pkg::*;
#(
   parameter int WIDTH2 = CLA_WIDTH,
   parameter int N_OPS  = 4,
   localparam int CNT_W = $clog2(N_OPS + 1)
) (
   input  logic              clk_pi,
   input  logic              rst_pi,
   input  logic              clear_pi,
   input  logic [WIDTH2-1:0] data_pi,
   input  logic              valid_pi,
   output logic              ready_po,
   input  logic              ack_pi,
   output logic [WIDTH2-1:0] result_po,
   output logic              ovf_po,
   output logic [CNT_W-1:0]  count_po,
   output logic              done_po
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

   cla_acc_state_t    state;
   cla_acc_state_t    state_next;
   logic [WIDTH2-1:0] acc;
   logic [WIDTH2-1:0] sum;
   logic              ovf;
   logic [CNT_W-1:0]  count;
   logic              beat;
   logic              wrap;

   module_cla_8bits #(.WIDTH2(WIDTH2)) u_cla (
      .a_pi      (acc),
      .b_pi      (data_pi),
      .result_po (sum)
   );

   // The CLA has no carry-out, so a wrap shows up as the new sum being
   // smaller than the running total.
   assign wrap = (sum < acc);
   assign beat = valid_pi && ready_po;

   // Next-state and handshake decode. ready/done come only from the state
   // register so there is no combinational path from valid_pi to ready_po.
   always_comb begin
      state_next = state;
      ready_po   = (state != ST_DONE);
      done_po    = (state == ST_DONE);
      if (clear_pi) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (beat) state_next = ST_ACC;
            ST_ACC:  if (beat && (count == LAST_CNT)) state_next = ST_DONE;
            ST_DONE: if (ack_pi) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Datapath registers. clear_pi drops any beat in the same cycle; in
   // ST_DONE everything holds until the consumer acknowledges.
   always_ff @(posedge clk_pi or posedge rst_pi) begin
      if (rst_pi) begin
         state <= ST_IDLE;
         acc   <= '0;
         ovf   <= 1'b0;
         count <= '0;
      end else begin
         state <= state_next;
         if (clear_pi) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (beat) begin
                     acc   <= sum;
                     count <= CNT_W'(1);
                  end
               end
               ST_ACC: begin
                  if (beat) begin
                     acc   <= sum;
                     ovf   <= ovf | wrap;
                     count <= count + CNT_W'(1);
                  end
               end
               ST_DONE: begin
                  if (ack_pi) begin
                     acc   <= '0;
                     ovf   <= 1'b0;
                     count <= '0;
                  end
               end
               default: begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  count <= '0;
               end
            endcase
         end
      end
   end

   assign result_po = acc;
   assign ovf_po    = ovf;
   assign count_po  = count;

endmodule : module_cla_accumulator_8bits

// File: tb/tb_module_cla_accumulator_8bits.sv
// ---------------------------------------------------------------------------
// tb_module_cla_accumulator_8bits
// Directed self-checking bench for the CLA accumulator with default
// parameters (WIDTH2=8, N_OPS=4). Inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_module_cla_accumulator_8bits;

   logic       clk_pi;
   logic       rst_pi;
   logic       clear_pi;
   logic [7:0] data_pi;
   logic       valid_pi;
   logic       ready_po;
   logic       ack_pi;
   logic [7:0] result_po;
   logic       ovf_po;
   logic [2:0] count_po;
   logic       done_po;

   int checks_total;
   int checks_passed;

   module_cla_accumulator_8bits #(.WIDTH2(8), .N_OPS(4)) dut (
      .clk_pi    (clk_pi),
      .rst_pi    (rst_pi),
      .clear_pi  (clear_pi),
      .data_pi   (data_pi),
      .valid_pi  (valid_pi),
      .ready_po  (ready_po),
      .ack_pi    (ack_pi),
      .result_po (result_po),
      .ovf_po    (ovf_po),
      .count_po  (count_po),
      .done_po   (done_po)
   );

   // 10 ns clock period
   initial clk_pi = 1'b0;
   always #5 clk_pi = ~clk_pi;

   // Presents one operand for exactly one rising edge, returning on the
   // following falling edge with valid dropped.
   task automatic apply_beat(input logic [7:0] d);
      data_pi  = d;
      valid_pi = 1'b1;
      @(negedge clk_pi);
      valid_pi = 1'b0;
   endtask

   // Pulses ack for one rising edge to release ST_DONE.
   task automatic apply_ack();
      ack_pi = 1'b1;
      @(negedge clk_pi);
      ack_pi = 1'b0;
   endtask

   task automatic test_reset();
      rst_pi   = 1'b1;
      clear_pi = 1'b0;
      valid_pi = 1'b0;
      ack_pi   = 1'b0;
      data_pi  = 8'd0;
      @(negedge clk_pi);
      @(negedge clk_pi);
      checks_total++;
      if ({result_po, ovf_po, count_po, done_po, ready_po} !== {8'd0, 1'b0, 3'd0, 1'b0, 1'b1})
         $display("[TB] FAIL reset_state: got res=%0d ovf=%b cnt=%0d done=%b rdy=%b want res=0 ovf=0 cnt=0 done=0 rdy=1",
                  result_po, ovf_po, count_po, done_po, ready_po);
      else checks_passed++;
      rst_pi = 1'b0;
      @(negedge clk_pi);
   endtask

   task automatic test_basic();
      apply_beat(8'd10);
      apply_beat(8'd20);
      apply_beat(8'd30);
      checks_total++;
      if ({done_po, count_po, result_po} !== {1'b0, 3'd3, 8'd60})
         $display("[TB] FAIL basic_after3: got done=%b cnt=%0d res=%0d want done=0 cnt=3 res=60",
                  done_po, count_po, result_po);
      else checks_passed++;
      apply_beat(8'd40);
      checks_total++;
      if ({result_po, ovf_po, done_po, ready_po, count_po} !== {8'd100, 1'b0, 1'b1, 1'b0, 3'd4})
         $display("[TB] FAIL basic_done: got res=%0d ovf=%b done=%b rdy=%b cnt=%0d want res=100 ovf=0 done=1 rdy=0 cnt=4",
                  result_po, ovf_po, done_po, ready_po, count_po);
      else checks_passed++;
   endtask

   task automatic test_hold();
      data_pi  = 8'd99;
      valid_pi = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_pi);
         checks_total++;
         if ({result_po, ready_po, done_po} !== {8'd100, 1'b0, 1'b1})
            $display("[TB] FAIL hold_cycle%0d: got res=%0d rdy=%b done=%b want res=100 rdy=0 done=1",
                     i, result_po, ready_po, done_po);
         else checks_passed++;
      end
      valid_pi = 1'b0;
      apply_ack();
      checks_total++;
      if ({ready_po, count_po, done_po, result_po} !== {1'b1, 3'd0, 1'b0, 8'd0})
         $display("[TB] FAIL hold_ack: got rdy=%b cnt=%0d done=%b res=%0d want rdy=1 cnt=0 done=0 res=0",
                  ready_po, count_po, done_po, result_po);
      else checks_passed++;
   endtask

   task automatic test_wrap();
      apply_beat(8'd200);
      checks_total++;
      if (ovf_po !== 1'b0)
         $display("[TB] FAIL wrap_first: got ovf=%b want ovf=0", ovf_po);
      else checks_passed++;
      apply_beat(8'd100);
      apply_beat(8'd0);
      apply_beat(8'd0);
      checks_total++;
      if ({result_po, ovf_po, done_po} !== {8'd44, 1'b1, 1'b1})
         $display("[TB] FAIL wrap_result: got res=%0d ovf=%b done=%b want res=44 ovf=1 done=1",
                  result_po, ovf_po, done_po);
      else checks_passed++;
      apply_ack();
      checks_total++;
      if (ovf_po !== 1'b0)
         $display("[TB] FAIL wrap_ack_ovf: got ovf=%b want ovf=0", ovf_po);
      else checks_passed++;
   endtask

   task automatic test_gaps();
      logic [7:0] ops [4];
      ops = '{8'd1, 8'd2, 8'd3, 8'd4};
      for (int i = 0; i < 4; i++) begin
         apply_beat(ops[i]);
         checks_total++;
         if (count_po !== 3'(i + 1))
            $display("[TB] FAIL gaps_count%0d: got cnt=%0d want cnt=%0d", i, count_po, i + 1);
         else checks_passed++;
         if (i < 3) begin
            // ack outside ST_DONE must be ignored during the idle gap
            ack_pi = 1'b1;
            repeat (3) @(negedge clk_pi);
            ack_pi = 1'b0;
         end
      end
      checks_total++;
      if ({result_po, ovf_po, done_po} !== {8'd10, 1'b0, 1'b1})
         $display("[TB] FAIL gaps_result: got res=%0d ovf=%b done=%b want res=10 ovf=0 done=1",
                  result_po, ovf_po, done_po);
      else checks_passed++;
      apply_ack();
   endtask

   task automatic test_clear();
      apply_beat(8'd50);
      apply_beat(8'd60);
      checks_total++;
      if ({count_po, result_po} !== {3'd2, 8'd110})
         $display("[TB] FAIL clear_pre: got cnt=%0d res=%0d want cnt=2 res=110", count_po, result_po);
      else checks_passed++;
      clear_pi = 1'b1;
      apply_beat(8'd7);
      clear_pi = 1'b0;
      checks_total++;
      if ({count_po, result_po, ready_po, done_po} !== {3'd0, 8'd0, 1'b1, 1'b0})
         $display("[TB] FAIL clear_post: got cnt=%0d res=%0d rdy=%b done=%b want cnt=0 res=0 rdy=1 done=0",
                  count_po, result_po, ready_po, done_po);
      else checks_passed++;
      apply_beat(8'd1);
      apply_beat(8'd2);
      apply_beat(8'd3);
      apply_beat(8'd4);
      checks_total++;
      if ({result_po, done_po, ovf_po} !== {8'd10, 1'b1, 1'b0})
         $display("[TB] FAIL clear_restart: got res=%0d done=%b ovf=%b want res=10 done=1 ovf=0",
                  result_po, done_po, ovf_po);
      else checks_passed++;
      apply_ack();
   endtask

   task automatic test_async_reset();
      apply_beat(8'd5);
      apply_beat(8'd5);
      // falling edge is at t; next rising edge at t+5
      #2 rst_pi = 1'b1;
      #1;
      checks_total++;
      if ({result_po, count_po, ready_po, done_po} !== {8'd0, 3'd0, 1'b1, 1'b0})
         $display("[TB] FAIL async_reset: got res=%0d cnt=%0d rdy=%b done=%b want res=0 cnt=0 rdy=1 done=0",
                  result_po, count_po, ready_po, done_po);
      else checks_passed++;
      #1 rst_pi = 1'b0;
      @(negedge clk_pi);
      apply_beat(8'd5);
      checks_total++;
      if ({count_po, result_po} !== {3'd1, 8'd5})
         $display("[TB] FAIL async_restart: got cnt=%0d res=%0d want cnt=1 res=5", count_po, result_po);
      else checks_passed++;
      apply_beat(8'd5);
      apply_beat(8'd5);
      apply_beat(8'd5);
      checks_total++;
      if ({result_po, done_po} !== {8'd20, 1'b1})
         $display("[TB] FAIL async_result: got res=%0d done=%b want res=20 done=1", result_po, done_po);
      else checks_passed++;
      apply_ack();
   endtask

   // Scenarios run in order; hold relies on the ST_DONE left by basic.
   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_basic();
      test_hold();
      test_wrap();
      test_gaps();
      test_clear();
      test_async_reset();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule : tb_module_cla_accumulator_8bits
